systolic_ctrl: RTL and testbench

- Sequencer for an N x N output-stationary systolic array of MAC nodes. Each node registers a/b, passes them right/down, and accumulates c += a*b.
- Accepts a start/done job handshake and clears the array accumulators.
- Generates skewed per-row A-buffer and per-column B-buffer read addresses with zero-injection masks, waits for the pipeline to drain, then streams the N result rows out under valid/ready.
- Sits between the job front-end, the operand buffers and the array.

---
 rtl/systolic_pkg.sv | 21 ++
 rtl/skew_gen.sv | 28 ++
 rtl/systolic_ctrl.sv | 123 ++++++++++++
 tb/tb_systolic_ctrl.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/systolic_pkg.sv
// Shared types and helpers for the systolic array sequencer.
package systolic_pkg;

   typedef enum logic [2:0] {
      IDLE,
      CLEAR,
      FEED,
      SETTLE,
      READ,
      FIN
   } ctrl_state_t;

   localparam int N_DEF     = 4;
   localparam int MAX_K_DEF = 64;

   // Cycles needed to push K operands through the skewed N x N wavefront.
   function automatic int feed_len(input int k, input int n);
      return k + 2 * n - 2;
   endfunction

endpackage

// File: rtl/skew_gen.sv
// Per-lane skewed read enable/address generator: lane i reads element t-i while i <= t < i+K.
module skew_gen #(
   parameter  int N  = 4,
   parameter  int KW = 7,
   localparam int TW = KW + $clog2(2 * N)
) (
   input  logic [TW-1:0]   t,
   input  logic [KW-1:0]   k_r,
   input  logic            active,
   output logic [N-1:0]    en,
   output logic [N*KW-1:0] addr
);

   for (genvar i = 0; i < N; i++) begin : g_lane
      logic [TW-1:0] lo;
      logic [TW-1:0] hi;
      logic [TW-1:0] off;

      assign lo  = TW'(i);
      assign hi  = lo + TW'(k_r);
      assign off = t - lo;

      // Disabled lanes present address 0 so the buffer sees a quiet bus.
      assign en[i]              = active && (t >= lo) && (t < hi);
      assign addr[i*KW +: KW]   = en[i] ? off[KW-1:0] : '0;
   end

endmodule

// File: rtl/systolic_ctrl.sv
// Job sequencer for an output-stationary N x N systolic MAC array:
// clear, skewed operand feed, pipeline drain, then row-by-row result readout.
module systolic_ctrl
   import systolic_pkg::*;
#(
   parameter  int N        = N_DEF,
   parameter  int MAX_K    = MAX_K_DEF,
   parameter  int PIPE_LAT = 2,
   parameter  int KW       = $clog2(MAX_K + 1),
   localparam int TW       = KW + $clog2(2 * N),
   localparam int SW       = $clog2(PIPE_LAT + 1),
   localparam int RW       = $clog2(N)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [KW-1:0]   k_len,
   output logic            busy,
   output logic            done,
   output logic            array_clr,
   output logic [N-1:0]    a_rd_en,
   output logic [N*KW-1:0] a_rd_addr,
   output logic [N-1:0]    b_rd_en,
   output logic [N*KW-1:0] b_rd_addr,
   output logic            res_valid,
   input  logic            res_ready,
   output logic [RW-1:0]   res_row
);

   ctrl_state_t   state;
   ctrl_state_t   state_next;
   logic [KW-1:0] k_r;
   logic [TW-1:0] t;
   logic [SW-1:0] settle_cnt;
   logic [RW-1:0] row;
   logic [TW-1:0] last_t;
   logic          feed_active;

   assign last_t      = TW'(feed_len(int'(k_r), N) - 1);
   assign feed_active = (state == FEED);

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples the values from before this edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         k_r        <= '0;
         t          <= '0;
         settle_cnt <= '0;
         row        <= '0;
      end else begin
         state <= state_next;
         unique case (state)
            IDLE: begin
               if (start) k_r <= k_len;
               t          <= '0;
               settle_cnt <= '0;
               row        <= '0;
            end
            FEED:    t <= (t == last_t) ? '0 : t + 1'b1;
            SETTLE:  settle_cnt <= settle_cnt + 1'b1;
            READ:    if (res_ready) row <= row + 1'b1;
            default: ;
         endcase
      end
   end

   // NOTE: every signal gets a default before the case so no path leaves it
   // unassigned, which would infer a latch.
   always_comb begin
      state_next = state;
      busy       = 1'b0;
      done       = 1'b0;
      array_clr  = 1'b0;
      res_valid  = 1'b0;
      res_row    = '0;
      unique case (state)
         IDLE: if (start) state_next = CLEAR;
         CLEAR: begin
            busy       = 1'b1;
            array_clr  = 1'b1;
            state_next = (k_r != '0) ? FEED : SETTLE;
         end
         FEED: begin
            busy = 1'b1;
            if (t == last_t) state_next = SETTLE;
         end
         SETTLE: begin
            busy = 1'b1;
            if (settle_cnt == SW'(PIPE_LAT - 1)) state_next = READ;
         end
         READ: begin
            busy      = 1'b1;
            res_valid = 1'b1;
            res_row   = row;
            if (res_ready && row == RW'(N - 1)) state_next = FIN;
         end
         FIN: begin
            done       = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Rows (A) and columns (B) share the same skew rule.
   skew_gen #(.N(N), .KW(KW)) u_skew_a (
      .t      (t),
      .k_r    (k_r),
      .active (feed_active),
      .en     (a_rd_en),
      .addr   (a_rd_addr)
   );

   skew_gen #(.N(N), .KW(KW)) u_skew_b (
      .t      (t),
      .k_r    (k_r),
      .active (feed_active),
      .en     (b_rd_en),
      .addr   (b_rd_addr)
   );

endmodule

// File: tb/tb_systolic_ctrl.sv
// Directed self-checking bench for systolic_ctrl (N=4, MAX_K=64, PIPE_LAT=2).
module tb_systolic_ctrl;

   localparam int N  = 4;
   localparam int KW = 7;

   logic            clk = 1'b0;
   logic            rst;
   logic            start;
   logic [KW-1:0]   k_len;
   logic            busy;
   logic            done;
   logic            array_clr;
   logic [N-1:0]    a_rd_en;
   logic [N*KW-1:0] a_rd_addr;
   logic [N-1:0]    b_rd_en;
   logic [N*KW-1:0] b_rd_addr;
   logic            res_valid;
   logic            res_ready;
   logic [1:0]      res_row;

   int checks = 0;
   int errors = 0;

   systolic_ctrl dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .k_len     (k_len),
      .busy      (busy),
      .done      (done),
      .array_clr (array_clr),
      .a_rd_en   (a_rd_en),
      .a_rd_addr (a_rd_addr),
      .b_rd_en   (b_rd_en),
      .b_rd_addr (b_rd_addr),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res_row   (res_row)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Every output at its idle/reset value.
   task automatic check_quiet(input string tag);
      check({tag, "_busy"}, 32'(busy), 32'd0);
      check({tag, "_done"}, 32'(done), 32'd0);
      check({tag, "_clr"}, 32'(array_clr), 32'd0);
      check({tag, "_a_en"}, 32'(a_rd_en), 32'd0);
      check({tag, "_b_en"}, 32'(b_rd_en), 32'd0);
      check({tag, "_a_addr"}, 32'(a_rd_addr), 32'd0);
      check({tag, "_b_addr"}, 32'(b_rd_addr), 32'd0);
      check({tag, "_valid"}, 32'(res_valid), 32'd0);
      check({tag, "_row"}, 32'(res_row), 32'd0);
   endtask

   // Run one job with res_ready held high; returns at the done cycle.
   // Cycle numbers count from the start-accept cycle (cycle 0).
   task automatic run_job(input logic [KW-1:0] k, input bit hold,
                          output int done_cyc, output int en_cyc, output int clr_cyc,
                          output int rows, output int last3, output int order_err);
      logic [KW-1:0] a3;
      done_cyc = -1; en_cyc = 0; clr_cyc = 0; rows = 0; last3 = -1; order_err = 0;
      start = 1'b1;
      k_len = k;
      for (int c = 1; c <= 300; c++) begin
         tick();
         if (!hold) start = 1'b0;
         if (a_rd_en != '0) en_cyc++;
         if (b_rd_en != a_rd_en || b_rd_addr != a_rd_addr) order_err++;
         if (a_rd_en[3]) begin
            a3 = a_rd_addr[3*KW +: KW];
            last3 = int'(a3);
         end
         if (array_clr) clr_cyc++;
         if (res_valid) begin
            if (int'(res_row) != rows) order_err++;
            rows++;
         end
         if (done) begin
            done_cyc = c;
            break;
         end
      end
      check("job_done_seen", 32'(done), 32'd1);
   endtask

   // Hand-derived enable pattern for K=3, t = 0..8.
   logic [3:0] exp_en_k3 [9] = '{4'b0001, 4'b0011, 4'b0111, 4'b1110, 4'b1100,
                                 4'b1000, 4'b0000, 4'b0000, 4'b0000};

   initial begin
      int dc, ec, cc, rw, l3, oe;
      logic [KW-1:0] ad;

      rst = 1'b1; start = 1'b0; k_len = '0; res_ready = 1'b1;
      tick(); tick();
      check_quiet("reset");
      rst = 1'b0;
      tick();

      // Job 1: K=3, cycle-by-cycle timing and skew.
      start = 1'b1; k_len = 7'd3;
      tick();                                   // cycle 1
      start = 1'b0;
      check("k3_c1_clr", 32'(array_clr), 32'd1);
      check("k3_c1_busy", 32'(busy), 32'd1);
      check("k3_c1_en", 32'(a_rd_en), 32'd0);
      for (int t = 0; t < 9; t++) begin
         tick();                                // cycles 2..10
         check($sformatf("k3_t%0d_a_en", t), 32'(a_rd_en), 32'(exp_en_k3[t]));
         check($sformatf("k3_t%0d_b_en", t), 32'(b_rd_en), 32'(exp_en_k3[t]));
         check($sformatf("k3_t%0d_clr", t), 32'(array_clr), 32'd0);
         for (int i = 0; i < N; i++) begin
            ad = a_rd_addr[i*KW +: KW];
            check($sformatf("k3_t%0d_a_addr%0d", t, i), 32'(ad),
                  exp_en_k3[t][i] ? 32'(t - i) : 32'd0);
            ad = b_rd_addr[i*KW +: KW];
            check($sformatf("k3_t%0d_b_addr%0d", t, i), 32'(ad),
                  exp_en_k3[t][i] ? 32'(t - i) : 32'd0);
         end
      end
      for (int s = 0; s < 2; s++) begin
         tick();                                // cycles 11,12
         check("k3_settle_busy", 32'(busy), 32'd1);
         check("k3_settle_en", 32'({a_rd_en, b_rd_en}), 32'd0);
         check("k3_settle_valid", 32'(res_valid), 32'd0);
      end
      for (int r = 0; r < N; r++) begin
         tick();                                // cycles 13..16
         check("k3_read_valid", 32'(res_valid), 32'd1);
         check("k3_read_row", 32'(res_row), 32'(r));
         check("k3_read_busy", 32'(busy), 32'd1);
         check("k3_read_done", 32'(done), 32'd0);
      end
      tick();                                   // cycle 17
      check("k3_fin_done", 32'(done), 32'd1);
      check("k3_fin_busy", 32'(busy), 32'd0);
      check("k3_fin_valid", 32'(res_valid), 32'd0);
      tick();                                   // cycle 18
      check_quiet("k3_idle");

      // Job 2: K=0 -> CLEAR, SETTLE(2), 4 rows, done at cycle 8.
      run_job(7'd0, 1'b0, dc, ec, cc, rw, l3, oe);
      check("k0_done_cycle", 32'(dc), 32'd8);
      check("k0_en_cycles", 32'(ec), 32'd0);
      check("k0_clr_cycles", 32'(cc), 32'd1);
      check("k0_rows", 32'(rw), 32'd4);
      check("k0_order", 32'(oe), 32'd0);
      tick();

      // Job 3: K=2 with 5 cycles of backpressure at READ.
      start = 1'b1; k_len = 7'd2; res_ready = 1'b0;
      tick();
      start = 1'b0;
      for (int c = 0; c < 40 && !res_valid; c++) tick();
      check("bp_valid_reached", 32'(res_valid), 32'd1);
      for (int c = 0; c < 5; c++) begin
         check("bp_hold_valid", 32'(res_valid), 32'd1);
         check("bp_hold_row", 32'(res_row), 32'd0);
         tick();
      end
      res_ready = 1'b1;
      for (int r = 0; r < N; r++) begin
         check("bp_row", 32'(res_row), 32'(r));
         check("bp_row_valid", 32'(res_valid), 32'd1);
         check("bp_row_done", 32'(done), 32'd0);
         tick();
      end
      check("bp_done", 32'(done), 32'd1);
      tick();
      check("bp_done_pulse", 32'(done), 32'd0);

      // Job 4: reset at FEED t=4 (cycle 6), then K=1 runs cleanly.
      start = 1'b1; k_len = 7'd3;
      tick();
      start = 1'b0;
      for (int c = 2; c <= 6; c++) tick();
      check("rst_mid_en_t4", 32'(a_rd_en), 32'b1100);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_quiet("rst_mid");
      for (int c = 0; c < 3; c++) begin
         tick();
         check("rst_mid_no_done", 32'({done, busy}), 32'd0);
      end
      run_job(7'd1, 1'b0, dc, ec, cc, rw, l3, oe);
      check("k1_done_cycle", 32'(dc), 32'd15);
      check("k1_en_cycles", 32'(ec), 32'd4);
      check("k1_last_row3_addr", 32'(l3), 32'd0);
      check("k1_rows", 32'(rw), 32'd4);
      check("k1_order", 32'(oe), 32'd0);
      tick();

      // Job 5: K=MAX_K with start held high throughout.
      run_job(7'd64, 1'b1, dc, ec, cc, rw, l3, oe);
      check("k64_done_cycle", 32'(dc), 32'd78);
      check("k64_en_cycles", 32'(ec), 32'd67);
      check("k64_clr_cycles", 32'(cc), 32'd1);
      check("k64_last_row3_addr", 32'(l3), 32'd63);
      check("k64_rows", 32'(rw), 32'd4);
      check("k64_order", 32'(oe), 32'd0);
      check("k64_fin_busy", 32'(busy), 32'd0);
      tick();                                   // IDLE, start still high
      check("k64_idle_busy", 32'(busy), 32'd0);
      check("k64_idle_clr", 32'(array_clr), 32'd0);
      tick();                                   // second job accepted
      check("k64_rejob_clr", 32'(array_clr), 32'd1);
      check("k64_rejob_busy", 32'(busy), 32'd1);
      start = 1'b0;
      for (int c = 0; c < 100 && !done; c++) tick();
      check("k64_rejob_done", 32'(done), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
